// File: rtl/bm_msg_ctrl.sv
// MIL-STD-1553 style RT receive message controller: validates the command word,
// buffers up to 32 data words and holds the completed message until the host acks it.
module bm_msg_ctrl #(
  parameter int unsigned WORD_TIMEOUT = 200,
  parameter int unsigned MAX_WORDS    = 32
) (
  input  logic        clk_8M,
  input  logic        clrn,
  input  logic [15:0] word_in,
  input  logic        word_en,
  input  logic [1:0]  word_type,
  input  logic [2:0]  dec_err,
  input  logic [4:0]  rt_addr,
  input  logic        msg_ack,
  input  logic [4:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic [15:0] cmd_word,
  output logic [5:0]  word_cnt,
  output logic        msg_valid,
  output logic        busy,
  output logic [3:0]  status
);

  localparam int unsigned TmoW = $clog2(WORD_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StRxData, StDone} state_e;

  state_e            state_q, state_d;
  logic [15:0]       cmd_q, cmd_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [5:0]        exp_q, exp_d;
  logic              ovr_q, ovr_d;
  logic              cerr_q, cerr_d;
  logic              terr_q, terr_d;
  logic              derr_q, derr_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [15:0]       rd_data_q;
  logic [15:0]       buf_q [MAX_WORDS];
  logic              buf_we;

  logic              cmd_ok;
  logic              addr_hit;
  logic [4:0]        sub_addr;

  assign cmd_ok   = word_en && (dec_err == 3'd0) && (word_type == 2'b01);
  assign addr_hit = (word_in[15:11] == rt_addr) || (word_in[15:11] == 5'd31);
  assign sub_addr = word_in[9:5];

  // Next-state: message sequencing, data-word counting, inter-word timeout and error flags.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    ovr_d   = ovr_q;
    cerr_d  = cerr_q;
    terr_d  = terr_q;
    derr_d  = derr_q;
    tmo_d   = tmo_q;
    buf_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_ok && addr_hit) begin
          cmd_d  = word_in;
          cnt_d  = 6'd0;
          ovr_d  = 1'b0;
          cerr_d = 1'b0;
          terr_d = 1'b0;
          derr_d = 1'b0;
          // Transmit and mode-code commands carry no receive data.
          if (word_in[10] || (sub_addr == 5'd0) || (sub_addr == 5'd31)) begin
            state_d = StDone;
          end else begin
            state_d = StRxData;
            tmo_d   = '0;
            exp_d   = (word_in[4:0] == 5'd0) ? 6'd32 : {1'b0, word_in[4:0]};
          end
        end
      end
      StRxData: begin
        if (word_en) begin
          // Any strobe restarts the gap timer, so a word always beats a coincident timeout.
          tmo_d = '0;
          if (dec_err != 3'd0) begin
            derr_d  = 1'b1;
            state_d = StDone;
          end else if (word_type == 2'b01) begin
            cerr_d  = 1'b1;
            state_d = StDone;
          end else if (word_type == 2'b10) begin
            if (cnt_q < 6'(MAX_WORDS)) begin
              buf_we = 1'b1;
              cnt_d  = cnt_q + 6'd1;
            end
            if (cnt_d == exp_q) begin
              state_d = StDone;
            end
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TmoW'(WORD_TIMEOUT)) begin
            terr_d  = 1'b1;
            cerr_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (msg_ack) begin
          state_d = StIdle;
        end else if (word_en) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk_8M) begin
    if (!clrn) begin
      state_q   <= StIdle;
      cmd_q     <= 16'd0;
      cnt_q     <= 6'd0;
      exp_q     <= 6'd0;
      ovr_q     <= 1'b0;
      cerr_q    <= 1'b0;
      terr_q    <= 1'b0;
      derr_q    <= 1'b0;
      tmo_q     <= '0;
      rd_data_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      ovr_q     <= ovr_d;
      cerr_q    <= cerr_d;
      terr_q    <= terr_d;
      derr_q    <= derr_d;
      tmo_q     <= tmo_d;
      rd_data_q <= buf_q[rd_addr];
    end
  end

  // Data buffer: no reset, written only while receiving.
  always_ff @(posedge clk_8M) begin
    if (buf_we) begin
      buf_q[cnt_q[4:0]] <= word_in;
    end
  end

  assign rd_data   = rd_data_q;
  assign cmd_word  = cmd_q;
  assign word_cnt  = cnt_q;
  assign msg_valid = (state_q == StDone);
  assign busy      = (state_q == StRxData);
  assign status    = {ovr_q, cerr_q, terr_q, derr_q};

endmodule

// File: tb/tb_bm_msg_ctrl.sv
// Bench for bm_msg_ctrl: message-level reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_bm_msg_ctrl;

  localparam int Tmo = 200;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [15:0] word_in = 16'd0;
  logic        word_en = 1'b0;
  logic [1:0]  word_type = 2'b00;
  logic [2:0]  dec_err = 3'd0;
  logic [4:0]  rt_addr = 5'd5;
  logic        msg_ack = 1'b0;
  logic [4:0]  rd_addr = 5'd0;
  logic [15:0] rd_data;
  logic [15:0] cmd_word;
  logic [5:0]  word_cnt;
  logic        msg_valid;
  logic        busy;
  logic [3:0]  status;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bm_msg_ctrl #(.WORD_TIMEOUT(Tmo), .MAX_WORDS(32)) dut (
    .clk_8M   (clk),
    .clrn     (clrn),
    .word_in  (word_in),
    .word_en  (word_en),
    .word_type(word_type),
    .dec_err  (dec_err),
    .rt_addr  (rt_addr),
    .msg_ack  (msg_ack),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .cmd_word (cmd_word),
    .word_cnt (word_cnt),
    .msg_valid(msg_valid),
    .busy     (busy),
    .status   (status)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- message-level reference model ----------------
  bit          live = 0;
  bit          m_valid, m_busy;
  logic [15:0] m_cmd;
  int          m_cnt, m_need, m_silence;
  bit          m_ovr, m_cerr, m_terr, m_derr;
  logic [15:0] m_mem [32];
  bit          m_wr [32];
  logic [15:0] m_rd;
  bit          m_rd_known;

  always @(posedge clk) begin
    if (!clrn) begin
      live = 1; m_valid = 0; m_busy = 0; m_cmd = 0; m_cnt = 0; m_silence = 0;
      {m_ovr, m_cerr, m_terr, m_derr} = 4'b0;
      m_rd = 0; m_rd_known = 1;
    end else if (live) begin
      m_rd_known = m_wr[rd_addr];
      m_rd = m_mem[rd_addr];
      if (m_valid) begin
        if (msg_ack) m_valid = 0;
        else if (word_en) m_ovr = 1;
      end else if (m_busy) begin
        if (word_en) begin
          m_silence = 0;
          if (dec_err != 0) begin m_derr = 1; m_busy = 0; m_valid = 1; end
          else if (word_type == 2'b01) begin m_cerr = 1; m_busy = 0; m_valid = 1; end
          else if (word_type == 2'b10) begin
            m_mem[m_cnt] = word_in; m_wr[m_cnt] = 1; m_cnt++;
            if (m_cnt == m_need) begin m_busy = 0; m_valid = 1; end
          end
        end else begin
          m_silence++;
          if (m_silence == Tmo) begin m_terr = 1; m_cerr = 1; m_busy = 0; m_valid = 1; end
        end
      end else if (word_en && dec_err == 0 && word_type == 2'b01 &&
                   (word_in[15:11] == rt_addr || word_in[15:11] == 31)) begin
        m_cmd = word_in; m_cnt = 0; {m_ovr, m_cerr, m_terr, m_derr} = 4'b0;
        if (word_in[10] || word_in[9:5] == 0 || word_in[9:5] == 31) m_valid = 1;
        else begin
          m_busy = 1; m_silence = 0;
          m_need = (word_in[4:0] == 0) ? 32 : int'(word_in[4:0]);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (live) begin
      check("msg_valid", 16'(msg_valid), 16'(m_valid));
      check("busy", 16'(busy), 16'(m_busy));
      check("cmd_word", cmd_word, m_cmd);
      check("word_cnt", 16'(word_cnt), 16'(m_cnt));
      check("status", 16'(status), 16'({m_ovr, m_cerr, m_terr, m_derr}));
      if (m_rd_known) check("rd_data", rd_data, m_rd);
    end
  end

  // ---------------- stimulus helpers (called just after a negedge) ----------------
  task automatic send(input logic [1:0] t, input logic [15:0] w, input logic [2:0] e);
    word_type = t; word_in = w; dec_err = e; word_en = 1'b1;
    @(negedge clk);
    word_en = 1'b0; dec_err = 3'd0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack();
    msg_ack = 1'b1;
    @(negedge clk);
    msg_ack = 1'b0;
  endtask

  logic [15:0] exp_rd [3];
  int n;

  initial begin
    exp_rd[0] = 16'h1111; exp_rd[1] = 16'h2222; exp_rd[2] = 16'h3333;
    gap(3);
    check("reset_valid", 16'(msg_valid), 16'd0);
    check("reset_cnt", 16'(word_cnt), 16'd0);
    clrn = 1'b1;
    gap(2);

    // Three-word receive at 160-cycle spacing.
    send(2'b01, 16'h2843, 3'd0);
    check("rx_busy", 16'(busy), 16'd1);
    for (int i = 0; i < 3; i++) begin
      gap(159);
      send(2'b10, exp_rd[i], 3'd0);
    end
    check("rx3_valid", 16'(msg_valid), 16'd1);
    check("rx3_cnt", 16'(word_cnt), 16'd3);
    check("rx3_status", 16'(status), 16'h0);
    check("rx3_cmd", cmd_word, 16'h2843);
    for (int i = 0; i < 3; i++) begin
      rd_addr = 5'(i);
      @(negedge clk);
      check("rx3_rd", rd_data, exp_rd[i]);
    end
    ack();
    check("ack_idle", 16'(msg_valid), 16'd0);

    // Short message then silence: timeout after exactly 200 cycles.
    send(2'b01, 16'h2845, 3'd0);
    gap(9);
    send(2'b10, 16'haaaa, 3'd0);
    gap(9);
    send(2'b10, 16'hbbbb, 3'd0);
    n = 0;
    while (!msg_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", 16'(n), 16'd200);
    check("tmo_cnt", 16'(word_cnt), 16'd2);
    check("tmo_status", 16'(status), 16'b0110);
    ack();

    // Foreign RT ignored; broadcast accepted.
    send(2'b01, 16'h3843, 3'd0);
    for (int i = 0; i < 3; i++) begin gap(2); send(2'b10, 16'h7000 + 16'(i), 3'd0); end
    gap(5);
    check("rt7_valid", 16'(msg_valid), 16'd0);
    check("rt7_busy", 16'(busy), 16'd0);
    send(2'b01, 16'hF842, 3'd0);
    check("bc_busy", 16'(busy), 16'd1);
    send(2'b10, 16'h0b01, 3'd0);
    send(2'b10, 16'h0b02, 3'd0);
    check("bc_valid", 16'(msg_valid), 16'd1);
    check("bc_cnt", 16'(word_cnt), 16'd2);
    ack();

    // Transmit command: done immediately; extra word sets overrun.
    send(2'b01, 16'h2C20, 3'd0);
    check("tx_valid", 16'(msg_valid), 16'd1);
    check("tx_cnt", 16'(word_cnt), 16'd0);
    send(2'b10, 16'h5555, 3'd0);
    check("ovr_status", 16'(status), 16'b1000);
    ack();
    check("tx_ack", 16'(msg_valid), 16'd0);
    // Mode code, then ack coincident with a word: ack wins, no overrun.
    send(2'b01, 16'h2801, 3'd0);
    check("mode_valid", 16'(msg_valid), 16'd1);
    msg_ack = 1'b1;
    send(2'b10, 16'h6666, 3'd0);
    msg_ack = 1'b0;
    check("ackwin_valid", 16'(msg_valid), 16'd0);
    check("ackwin_status", 16'(status), 16'h0);

    // Count 0 means 32 words.
    send(2'b01, 16'h2840, 3'd0);
    for (int i = 0; i < 32; i++) begin gap(2); send(2'b10, 16'h1000 + 16'(i), 3'd0); end
    check("full_cnt", 16'(word_cnt), 16'd32);
    check("full_valid", 16'(msg_valid), 16'd1);
    rd_addr = 5'd31;
    gap(1);
    check("full_rd31", rd_data, 16'h101F);
    ack();

    // Decode error on second word.
    send(2'b01, 16'h2843, 3'd0);
    send(2'b10, 16'hc001, 3'd0);
    send(2'b10, 16'hc002, 3'b010);
    check("derr_status", 16'(status), 16'b0001);
    check("derr_cnt", 16'(word_cnt), 16'd1);
    ack();

    // Command word during reception.
    send(2'b01, 16'h2843, 3'd0);
    send(2'b10, 16'hd001, 3'd0);
    send(2'b01, 16'h2842, 3'd0);
    check("cerr_status", 16'(status), 16'b0100);
    check("cerr_cmd", cmd_word, 16'h2843);
    ack();

    // Reset during word 2 overrides the word, then a normal message.
    send(2'b01, 16'h2843, 3'd0);
    send(2'b10, 16'he001, 3'd0);
    clrn = 1'b0;
    send(2'b10, 16'he002, 3'd0);
    clrn = 1'b1;
    check("rst_valid", 16'(msg_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_cnt", 16'(word_cnt), 16'd0);
    check("rst_status", 16'(status), 16'd0);
    check("rst_cmd", cmd_word, 16'd0);
    check("rst_rd", rd_data, 16'd0);
    send(2'b01, 16'h2842, 3'd0);
    send(2'b10, 16'hf001, 3'd0);
    send(2'b10, 16'hf002, 3'd0);
    check("post_valid", 16'(msg_valid), 16'd1);
    check("post_cnt", 16'(word_cnt), 16'd2);
    rd_addr = 5'd1;
    gap(1);
    check("post_rd1", rd_data, 16'hf002);
    ack();
    gap(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
